// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath slice.
//
// Holds the sample and packed-word geometry, the frame/capture-slot timing
// constants and the serializer state encoding used by fft_demux and
// lane_serializer.
package fft_pkg;

    localparam int DW       = 34;               // 17-bit real + 17-bit imag
    localparam int LANES    = 4;                // samples per packed word
    localparam int FRAME    = 16;               // frame length in cycles
    localparam int CAP_SLOT = 2;                // slot whose word is serialized

    localparam int WORD_W   = DW * LANES;
    localparam int SLOT_W   = $clog2(FRAME);
    localparam int IDX_W    = $clog2(LANES);

    typedef logic [DW-1:0]      sample_t;
    typedef sample_t [LANES-1:0] word_t;        // lane k sits at [DW*k +: DW]

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/lane_serializer.sv
// Lane serializer: captures one packed word and emits its lanes one at a
// time, lane 0 first, over a ready/valid handshake.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   capture     - load cap_word this cycle (one cycle strobe)
//   cap_word    - packed word to serialize
//   ser_ready   - downstream accepts ser_data
//   ser_data    - current lane, 0 while idle
//   ser_valid   - ser_data is valid
//   overflow    - sticky, a capture arrived while a burst was in progress
module lane_serializer
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic [WORD_W-1:0] cap_word,
    input  logic              ser_ready,
    output logic [DW-1:0]     ser_data,
    output logic              ser_valid,
    output logic              overflow
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    ser_state_t       state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    word_t            lanes, lanes_next;
    logic             overflow_next;
    logic             last_handshake;

    // Handshake on the final lane frees the buffer this very edge, so a
    // capture landing on it is a legal reload rather than an overflow.
    assign last_handshake = (state == SHIFT) && ser_ready && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            lanes    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            lanes    <= lanes_next;
            overflow <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        lanes_next    = lanes;
        overflow_next = overflow;
        case (state)
            IDLE: begin
                if (capture) begin
                    lanes_next = cap_word;
                    idx_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_handshake) begin
                    if (capture) begin
                        lanes_next = cap_word;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    // Busy: the current burst keeps going, a new word is lost.
                    if (ser_ready) begin
                        idx_next = idx + 1'b1;
                    end
                    if (capture) begin
                        overflow_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs depend on registers only; data is forced to 0 while idle so a
    // stale lane never leaks onto the bus.
    assign ser_valid = (state == SHIFT);
    assign ser_data  = ser_valid ? lanes[idx] : '0;

endmodule

// File: rtl/fft_demux.sv
// Frame-slot demultiplexer on the FFT stage output bus.
//
// Every accepted word is routed to bus 1 or bus 2 by demux_flag, except in
// the capture slot of each 16-cycle frame, where it is handed to the lane
// serializer instead.
//
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   data_in, in_valid         - packed 4-lane input word and its valid
//   demux_flag                - 1 selects bus 1, 0 selects bus 2
//   data_out_1, out_valid_1   - registered bus 1 word and one-cycle pulse
//   data_out_2, out_valid_2   - registered bus 2 word and one-cycle pulse
//   ser_data, ser_valid       - serialized lane stream
//   ser_ready                 - downstream ready for the serial stream
//   overflow                  - sticky dropped-capture flag
module fft_demux
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] data_in,
    input  logic              in_valid,
    input  logic              demux_flag,
    output logic [WORD_W-1:0] data_out_1,
    output logic              out_valid_1,
    output logic [WORD_W-1:0] data_out_2,
    output logic              out_valid_2,
    output logic [DW-1:0]     ser_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              overflow
);

    localparam logic [SLOT_W-1:0] CAP_SLOT_V = SLOT_W'(CAP_SLOT);
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(FRAME - 1);

    logic [SLOT_W-1:0] slot;
    logic              capture;
    logic              route_1;
    logic              route_2;

    // Capture steals the word outright; demux_flag is irrelevant in that slot.
    assign capture = in_valid && (slot == CAP_SLOT_V);
    assign route_1 = in_valid && !capture && demux_flag;
    assign route_2 = in_valid && !capture && !demux_flag;

    // Free-running frame position, independent of traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (slot == LAST_SLOT) begin
            slot <= '0;
        end else begin
            slot <= slot + 1'b1;
        end
    end

    // Each bus only loads when selected; the other keeps its last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_1  <= '0;
            out_valid_1 <= 1'b0;
            data_out_2  <= '0;
            out_valid_2 <= 1'b0;
        end else begin
            out_valid_1 <= route_1;
            out_valid_2 <= route_2;
            if (route_1) begin
                data_out_1 <= data_in;
            end
            if (route_2) begin
                data_out_2 <= data_in;
            end
        end
    end

    lane_serializer u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (capture),
        .cap_word  (data_in),
        .ser_ready (ser_ready),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_fft_demux.sv
// Directed self-checking bench for fft_demux: reset, routing, capture and
// serialization, backpressure, overflow, reload on the last handshake and
// reset in the middle of a burst.
module tb_fft_demux;

    logic         clk;
    logic         rst_n;
    logic [135:0] data_in;
    logic         in_valid;
    logic         demux_flag;
    logic [135:0] data_out_1;
    logic         out_valid_1;
    logic [135:0] data_out_2;
    logic         out_valid_2;
    logic [33:0]  ser_data;
    logic         ser_valid;
    logic         ser_ready;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    int exp_slot = 0;

    fft_demux dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .in_valid    (in_valid),
        .demux_flag  (demux_flag),
        .data_out_1  (data_out_1),
        .out_valid_1 (out_valid_1),
        .data_out_2  (data_out_2),
        .out_valid_2 (out_valid_2),
        .ser_data    (ser_data),
        .ser_valid   (ser_valid),
        .ser_ready   (ser_ready),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; the bench tracks the frame slot.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) exp_slot = (exp_slot + 1) % 16;
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 16 && exp_slot != s; i++) tick();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        demux_flag = 1'b0;
        ser_ready  = 1'b0;
        data_in    = '0;
        exp_slot   = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [135:0] w;
        w = {34{4'h5}};
        do_reset();
        checks++;
        if ({out_valid_1, out_valid_2, ser_valid, overflow} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b, expected 0000",
                     {out_valid_1, out_valid_2, ser_valid, overflow});
        end
        checks++;
        if (data_out_1 !== '0 || data_out_2 !== '0 || ser_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h %h %h, expected all 0",
                     data_out_1, data_out_2, ser_data);
        end
        checks++;
        if (dut.slot !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_slot: got %0d, expected 0", dut.slot);
        end
        data_in = w; demux_flag = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid_1 !== 1'b1 || data_out_1 !== w || out_valid_2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_route: got v1=%b d1=%h v2=%b, expected v1=1 d1=%h v2=0",
                     out_valid_1, data_out_1, out_valid_2, w);
        end
        checks++;
        if (dut.slot !== 4'd1) begin
            errors++;
            $display("[TB] FAIL slot_count: got %0d, expected 1", dut.slot);
        end
    endtask

    task automatic test_routing();
        logic [135:0] w1, w2;
        w1 = (136'd1 << 132) | 136'd1;
        w2 = {34{4'hA}};
        wait_slot(4);
        data_in = w1; demux_flag = 1'b1; in_valid = 1'b1;
        tick();
        checks++;
        if (out_valid_1 !== 1'b1 || data_out_1 !== w1 || out_valid_2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL route_bus1: got v1=%b d1=%h v2=%b, expected v1=1 d1=%h v2=0",
                     out_valid_1, data_out_1, out_valid_2, w1);
        end
        data_in = w2; demux_flag = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid_2 !== 1'b1 || data_out_2 !== w2 || out_valid_1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL route_bus2: got v2=%b d2=%h v1=%b, expected v2=1 d2=%h v1=0",
                     out_valid_2, data_out_2, out_valid_1, w2);
        end
        checks++;
        if (data_out_1 !== w1) begin
            errors++;
            $display("[TB] FAIL bus1_hold: got %h, expected %h", data_out_1, w1);
        end
        tick();
        checks++;
        if (out_valid_1 !== 1'b0 || out_valid_2 !== 1'b0 || data_out_2 !== w2) begin
            errors++;
            $display("[TB] FAIL pulse_width: got v1=%b v2=%b d2=%h, expected 0 0 %h",
                     out_valid_1, out_valid_2, data_out_2, w2);
        end
    endtask

    task automatic test_capture();
        ser_ready = 1'b1;
        wait_slot(2);
        data_in = {34'h4, 34'h3, 34'h2, 34'h1}; demux_flag = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid_1 !== 1'b0 || out_valid_2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL capture_no_route: got v1=%b v2=%b, expected 0 0",
                     out_valid_1, out_valid_2);
        end
        checks++;
        if (ser_valid !== 1'b1 || ser_data !== 34'h1 || dut.slot !== 4'd3) begin
            errors++;
            $display("[TB] FAIL capture_lane0: got v=%b d=%h slot=%0d, expected v=1 d=1 slot=3",
                     ser_valid, ser_data, dut.slot);
        end
        for (int i = 2; i <= 4; i++) begin
            tick();
            checks++;
            if (ser_valid !== 1'b1 || ser_data !== 34'(i)) begin
                errors++;
                $display("[TB] FAIL serial_lane: got v=%b d=%h, expected v=1 d=%h",
                         ser_valid, ser_data, 34'(i));
            end
        end
        tick();
        checks++;
        if (ser_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL burst_end: got v=%b ovf=%b, expected 0 0", ser_valid, overflow);
        end
    endtask

    task automatic test_backpressure();
        ser_ready = 1'b1;
        wait_slot(2);
        data_in = {34'h4, 34'h3, 34'h2, 34'h1}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        ser_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (ser_valid !== 1'b1 || ser_data !== 34'h2) begin
                errors++;
                $display("[TB] FAIL bp_hold: got v=%b d=%h, expected v=1 d=2", ser_valid, ser_data);
            end
        end
        ser_ready = 1'b1;
        for (int i = 3; i <= 4; i++) begin
            tick();
            checks++;
            if (ser_valid !== 1'b1 || ser_data !== 34'(i)) begin
                errors++;
                $display("[TB] FAIL bp_resume: got v=%b d=%h, expected v=1 d=%h",
                         ser_valid, ser_data, 34'(i));
            end
        end
        tick();
        checks++;
        if (ser_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_end: got v=%b, expected 0", ser_valid);
        end
    endtask

    task automatic test_overflow();
        ser_ready = 1'b0;
        wait_slot(2);
        data_in = {34'h8, 34'h7, 34'h6, 34'h5}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_slot(2);
        data_in = {34'h1C, 34'h1B, 34'h1A, 34'h19}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || ser_valid !== 1'b1 || ser_data !== 34'h5) begin
            errors++;
            $display("[TB] FAIL overflow_set: got ovf=%b v=%b d=%h, expected 1 1 5",
                     overflow, ser_valid, ser_data);
        end
        ser_ready = 1'b1;
        for (int i = 6; i <= 8; i++) begin
            tick();
            checks++;
            if (ser_valid !== 1'b1 || ser_data !== 34'(i)) begin
                errors++;
                $display("[TB] FAIL overflow_burst: got v=%b d=%h, expected v=1 d=%h",
                         ser_valid, ser_data, 34'(i));
            end
        end
        tick();
        checks++;
        if (ser_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_sticky: got v=%b ovf=%b, expected 0 1", ser_valid, overflow);
        end
        do_reset();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_clear: got %b, expected 0", overflow);
        end
    endtask

    task automatic test_back_to_back();
        ser_ready = 1'b1;
        wait_slot(2);
        data_in = {34'h4, 34'h3, 34'h2, 34'h1}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        ser_ready = 1'b0;
        checks++;
        if (ser_data !== 34'h4 || dut.slot !== 4'd6) begin
            errors++;
            $display("[TB] FAIL b2b_lane3: got d=%h slot=%0d, expected d=4 slot=6", ser_data, dut.slot);
        end
        wait_slot(2);
        ser_ready = 1'b1;
        data_in = {34'h14, 34'h13, 34'h12, 34'h11}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (ser_valid !== 1'b1 || ser_data !== 34'h11 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_reload: got v=%b d=%h ovf=%b, expected 1 11 0",
                     ser_valid, ser_data, overflow);
        end
        for (int i = 'h12; i <= 'h14; i++) begin
            tick();
            checks++;
            if (ser_valid !== 1'b1 || ser_data !== 34'(i)) begin
                errors++;
                $display("[TB] FAIL b2b_burst: got v=%b d=%h, expected v=1 d=%h",
                         ser_valid, ser_data, 34'(i));
            end
        end
        tick();
        checks++;
        if (ser_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_end: got v=%b ovf=%b, expected 0 0", ser_valid, overflow);
        end
    endtask

    task automatic test_mid_reset();
        int bad;
        ser_ready = 1'b1;
        wait_slot(2);
        data_in = {34'h4, 34'h3, 34'h2, 34'h1}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        exp_slot = 0;
        #1;
        checks++;
        if (ser_valid !== 1'b0 || ser_data !== '0 || dut.slot !== 4'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got v=%b d=%h slot=%0d, expected 0 0 0",
                     ser_valid, ser_data, dut.slot);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ser_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL no_resume: got %0d cycles with ser_valid=1, expected 0", bad);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        demux_flag = 1'b0;
        ser_ready  = 1'b0;
        data_in    = '0;
        $display("[TB] starting fft_demux bench");
        test_reset();
        test_routing();
        test_capture();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_demux.md
# fft_demux

Frame-slot demultiplexer for the FFT datapath, sitting on the stage output bus. Each accepted 136-bit word (four 34-bit complex samples) is routed to one of two stage buses by `demux_flag`. In one fixed slot of every 16-cycle frame, the word is instead captured and unpacked into a serial 34-bit sample stream, one lane at a time, with ready/valid backpressure. Sticky overflow flags a capture that arrives while the serializer is still busy.

## Interface
- `DW`, 34, sample width (17-bit real + 17-bit imag)
- `LANES`, 4, samples per packed word; bus width = `DW*LANES` = 136
- `FRAME`, 16, frame length in cycles; the slot counter is `$clog2(FRAME)` = 4 bits
- `CAP_SLOT`, 2, slot whose word is captured for serialization

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `data_in`  in  136  packed word, lane k = `[34k+33:34k]`
- `in_valid`  in  1  `data_in` valid this cycle
- `demux_flag`  in  1  1 routes to bus 1, 0 routes to bus 2
- `data_out_1`  out  136  routed word, bus 1 (registered)
- `out_valid_1`  out  1  one-cycle pulse, `data_out_1` updated
- `data_out_2`  out  136  routed word, bus 2 (registered)
- `out_valid_2`  out  1  one-cycle pulse, `data_out_2` updated
- `ser_data`  out  34  current serial sample
- `ser_valid`  out  1  `ser_data` valid
- `ser_ready`  in  1  downstream accepts `ser_data`
- `overflow`  out  1  sticky: a capture was dropped

## Operation
- Slot counter `slot`:
  - Reset value 0.
  - Increments every cycle and wraps from 15 to 0.
  - Free-running, independent of `in_valid`.
- Routing, when `in_valid=1` and `slot != CAP_SLOT`:
  - `demux_flag=1`: `data_out_1 <= data_in`, `out_valid_1` pulses.
  - `demux_flag=0`: `data_out_2 <= data_in`, `out_valid_2` pulses.
  - The bus not selected holds its data and its valid is 0.
- Capture, when `in_valid=1` and `slot == CAP_SLOT`:
  - The word is loaded into the lane buffer and is not routed.
  - Both `out_valid_x` stay 0 that cycle.
  - `in_valid=0` at `CAP_SLOT` captures nothing.
- Serializer FSM:
  - IDLE: `ser_valid=0`. On a capture, load the 4 lanes, set `idx=0`, go to SHIFT.
  - SHIFT: `ser_valid=1`, `ser_data = lane[idx]`, lane 0 first.
    - A handshake (`ser_valid && ser_ready`) advances `idx`.
    - On the handshake of lane 3, go to IDLE.
    - Without `ser_ready`, `ser_data` and `idx` hold.
- Boundary cases:
  - Capture on the same cycle as the lane-3 handshake: reload, stay in SHIFT, no overflow.
  - Capture while in SHIFT in any other cycle: the new word is dropped, `overflow <= 1`, and the current burst continues unaffected.
  - `overflow` clears only on reset.
  - `demux_flag` is ignored at `CAP_SLOT`.
- Reset, asserted at any time:
  - `slot`, FSM, `idx`, lane buffer and all outputs go to 0 immediately.
  - Any partial burst is abandoned with no resumption.

## Timing
- Routing latency is 1 cycle: input sampled at edge N, `data_out_x`/`out_valid_x` valid after edge N, for one cycle.
- Capture at edge N: `ser_valid=1` with lane 0 after edge N.
- With `ser_ready` tied 1, lanes 0..3 appear on 4 consecutive cycles, i.e. slots 3,4,5,6 when the capture happens at slot 2.
- Burst end: `ser_valid` falls after the lane-3 handshake edge unless a reload occurs on that same edge.
- Throughput:
  - One routed word per cycle, with no backpressure on the routed buses.
  - One serialized word per frame.
  - Overflow is possible only if `ser_ready` is low for more than 12 cycles within a frame.
- No combinational path from inputs to outputs.

## Structure
- Shared package `fft_pkg`:
  - `DW`, `LANES`, `FRAME`, `CAP_SLOT` constants.
  - `sample_t` (34-bit) and `word_t` (136-bit) typedefs.
  - FSM state enum `ser_state_t` {IDLE, SHIFT}.
- One sub-module, `lane_serializer`: lane buffer, `idx`, FSM, ready/valid and overflow logic.
- Top level: slot counter, routing registers, capture decode.

## Test plan
- Reset check:
  - Stimulus: hold `rst_n=0` for 3 cycles, then release.
  - Required response:
    - All outputs read 0.
    - `slot` reads 0.
    - The first `in_valid` with `demux_flag=1` at slot 0 gives `out_valid_1` one cycle later.
- Routing:
  - Stimulus: at slots 4/5, word `0x1_0000...0001` with flag 1, then `0xA...A` with flag 0.
  - Required response:
    - `data_out_1` updates one cycle after the first word.
    - `data_out_2` updates one cycle after the second.
    - Each valid is a 1-cycle pulse; the idle bus holds.
- Capture/serialize:
  - Stimulus: at slot 2, lanes {3,2,1,0} = `{34'h4, 34'h3, 34'h2, 34'h1}`, with `ser_ready=1`.
  - Required response:
    - `ser_data` = 1,2,3,4 at slots 3..6.
    - No `out_valid_x` at slot 2.
- Backpressure:
  - Stimulus: same capture, with `ser_ready` low for 5 cycles after lane 1.
  - Required response: `ser_data` holds 2 and `ser_valid` holds 1; sequence completes with no drop or duplicate.
- Overflow and simultaneous event:
  - Stimulus: keep `ser_ready=0` across the next slot 2.
  - Required response: second word dropped, `overflow=1` and sticky.
  - Stimulus: separately, time the lane-3 handshake to coincide with a capture.
  - Required response: reload occurs, `ser_valid` stays 1, `overflow` stays 0.
- Mid-burst reset:
  - Stimulus: assert `rst_n` after lane 1 is accepted.
  - Required response:
    - `ser_valid` drops immediately.
    - After release, with no new capture, `ser_valid` stays 0.
